// File: rtl/design_33.sv
// Registered W-bit adder: a start pulse captures (a + b) mod 2^W into y,
// and valid follows one clock later as a one-cycle strobe.
module design_33 #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y,
   output logic         valid
);

   logic [W-1:0] sum_reg;
   logic         valid_reg;
   logic [W-1:0] sum_next;

   // Carry-out is dropped by the W-bit assignment width.
   assign sum_next = a + b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_reg   <= '0;
         valid_reg <= 1'b0;
      end else begin
         valid_reg <= start;
         if (start) begin
            sum_reg <= sum_next;
         end
      end
   end

   assign y     = sum_reg;
   assign valid = valid_reg;

endmodule

// File: tb/tb_design_33.sv
// Bench for design_33: vector table, multi-cycle reset/glitch sequences and
// a scoreboard-checked random section.
module tb_design_33;
   localparam int W = 16;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] y;
   logic         valid;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] sb[$];
   logic [W-1:0] last_y;

   typedef struct {
      logic         st;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         ev;
      logic [W-1:0] ey;
   } vec_t;

   vec_t vecs[11];

   design_33 #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .y     (y),
      .valid (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs just after a negedge, then sample at the next negedge.
   task automatic drive_cycle(input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb);
      start = s;
      a     = aa;
      b     = bb;
      @(negedge clk);
   endtask

   // Scoreboard-driven cycle: push on start, pop on valid.
   task automatic sb_cycle(input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb);
      logic [W-1:0] exp_sum;
      logic [W-1:0] got;
      exp_sum = aa + bb;
      if (s) sb.push_back(exp_sum);
      drive_cycle(s, aa, bb);
      check_bit("rand_valid", valid, s);
      if (valid) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rand_sb_empty actual=valid required=no_valid");
         end else begin
            got = sb.pop_front();
            check_word("rand_y", y, got);
            last_y = got;
         end
      end else begin
         check_word("rand_hold", y, last_y);
      end
      $display("rand start=%b a=%h b=%h -> valid=%b y=%h", s, aa, bb, valid, y);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 16'd100,  16'd23,   1'b1, 16'd123};
      vecs[1]  = '{1'b0, 16'd0,    16'd0,    1'b0, 16'd123};
      vecs[2]  = '{1'b1, 16'hFFFF, 16'h0002, 1'b1, 16'h0001};
      vecs[3]  = '{1'b1, 16'hFFFF, 16'h0001, 1'b1, 16'h0000};
      vecs[4]  = '{1'b1, 16'd1,    16'd2,    1'b1, 16'd3};
      vecs[5]  = '{1'b1, 16'd10,   16'd20,   1'b1, 16'd30};
      vecs[6]  = '{1'b0, 16'd5,    16'd5,    1'b0, 16'd30};
      vecs[7]  = '{1'b1, 16'h8000, 16'h8000, 1'b1, 16'h0000};
      vecs[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
      vecs[9]  = '{1'b1, 16'h1234, 16'h4321, 1'b1, 16'h5555};
      vecs[10] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 16'h5555};

      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;

      // Reset held for 3 cycles while start toggles.
      for (int i = 0; i < 3; i++) begin
         drive_cycle((i % 2) == 0, 16'd7, 16'd8);
         check_bit("reset_valid", valid, 1'b0);
         check_word("reset_y", y, '0);
         $display("reset cycle %0d start=%b -> valid=%b y=%h", i, start, valid, y);
      end
      rst_n = 1'b1;
      drive_cycle(1'b0, '0, '0);
      check_bit("post_reset_valid", valid, 1'b0);
      check_word("post_reset_y", y, '0);

      for (int i = 0; i < 11; i++) begin
         drive_cycle(vecs[i].st, vecs[i].a, vecs[i].b);
         check_bit($sformatf("vec%0d_valid", i), valid, vecs[i].ev);
         check_word($sformatf("vec%0d_y", i), y, vecs[i].ey);
         $display("vec %0d start=%b a=%h b=%h -> valid=%b y=%h", i, vecs[i].st, vecs[i].a, vecs[i].b, valid, y);
      end

      // Start pulsing between edges must not be captured.
      start = 1'b0;
      #1 start = 1'b1; a = 16'd1; b = 16'd1;
      #2 start = 1'b0;
      @(negedge clk);
      check_bit("glitch_valid", valid, 1'b0);
      check_word("glitch_y", y, 16'h5555);
      $display("glitch -> valid=%b y=%h", valid, y);

      // Reset mid-operation with a start pending.
      drive_cycle(1'b1, 16'd7, 16'd9);
      check_bit("midop_pre_valid", valid, 1'b1);
      check_word("midop_pre_y", y, 16'd16);
      start = 1'b1;
      a     = 16'd3;
      b     = 16'd3;
      #2 rst_n = 1'b0;
      #1;
      check_bit("midop_async_valid", valid, 1'b0);
      check_word("midop_async_y", y, '0);
      @(negedge clk);
      check_bit("midop_hold_valid", valid, 1'b0);
      check_word("midop_hold_y", y, '0);
      $display("midop reset -> valid=%b y=%h", valid, y);
      rst_n = 1'b1;
      drive_cycle(1'b0, '0, '0);
      check_bit("midop_release_valid", valid, 1'b0);
      check_word("midop_release_y", y, '0);
      drive_cycle(1'b1, 16'd40, 16'd2);
      check_bit("first_start_valid", valid, 1'b1);
      check_word("first_start_y", y, 16'd42);
      $display("after release start a=40 b=2 -> valid=%b y=%h", valid, y);

      // Random section: 10 starts spaced 4 cycles apart.
      last_y = 16'd42;
      drive_cycle(1'b0, '0, '0);
      for (int n = 0; n < 10; n++) begin
         sb_cycle(1'b1, 16'($urandom_range(1023, 0)), 16'($urandom_range(1023, 0)));
         for (int k = 0; k < 3; k++) begin
            sb_cycle(1'b0, 16'($urandom_range(1023, 0)), 16'($urandom_range(1023, 0)));
         end
      end
      check_word("sb_drained", 16'(sb.size()), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/design_33.md
DESIGN_33 -- requirements
Module: design_33

Interface
REQ-001 The module SHALL have parameter W, default 16, giving the bit width of operands and result; W SHALL be at least 1.
REQ-002 clk  input  1  The module SHALL treat clk as the clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  The module SHALL use rst_n as its reset: asynchronous, active-low.
REQ-004 start  input  1  The module SHALL treat start as a single-cycle request to add the operands, sampled on the rising edge of clk.
REQ-005 a  input  W  The module SHALL take a as operand A, sampled on the same edge as start.
REQ-006 b  input  W  The module SHALL take b as operand B, sampled on the same edge as start.
REQ-007 y  output  W  The module SHALL drive y with the registered sum result.
REQ-008 valid  output  1  The module SHALL drive valid as a result-valid strobe, registered.

Function
REQ-009 On a rising edge with rst_n high and start=1, the module SHALL load y with (a + b) mod 2^W, using values sampled at that edge.
REQ-010 The module SHALL set valid=1 in the cycle immediately after a start edge: fixed latency of 1 clock, with no combinational path from start, a or b to y or valid.
REQ-011 On a rising edge with start=0, the module SHALL clear valid to 0, so valid is a one-cycle pulse per isolated start.
REQ-012 With start=0, the module SHALL hold y at its last computed value; y is not required to return to 0.
REQ-013 Back-to-back start on consecutive edges SHALL keep valid=1 continuously, and y SHALL update every cycle to the sum of the operands sampled on the previous edge.
REQ-014 Whenever valid=1, y SHALL equal the W-bit sum of the a and b sampled on the most recent start edge.
REQ-015 Carry-out beyond bit W-1 SHALL be discarded, with no overflow flag; e.g. W=16, a=16'hFFFF, b=16'h0001 gives y=16'h0000.
REQ-016 The module SHALL have no busy state and SHALL accept start on every cycle.
REQ-017 Changes on a, b or start between clock edges SHALL have no effect on y or valid.

Reset
REQ-018 While rst_n=0, the module SHALL hold valid=0 and y=0 immediately, independent of clk, and SHALL ignore start.
REQ-019 Reset asserted mid-operation SHALL drop a pending valid pulse: valid=0 throughout reset and no stale valid after release.
REQ-020 After rst_n deasserts, the first rising edge SHALL operate normally; start on that edge SHALL produce valid=1 on the next cycle.
REQ-021 After reset the module SHALL keep y=0 and valid=0 until the first start.

Verification
REQ-022 Reset: hold rst_n=0 for 3 cycles with start toggling -> valid=0 and y=0 on every edge.
REQ-023 Single start: a=100, b=23, start for 1 cycle -> next cycle valid=1 and y=123; the cycle after, valid=0 and y remains 123.
REQ-024 Wrap: W=16, a=16'hFFFF, b=16'h0002, start -> valid=1 and y=16'h0001 one cycle later.
REQ-025 Back-to-back: start on 2 consecutive edges with (1,2) then (10,20) -> valid high for 2 cycles, with y=3 then y=30.
REQ-026 Random: 10 starts spaced 4 cycles apart with a,b in [0,1023] -> every start is followed by valid, and y equals a reference sum registered on start whenever valid=1.
REQ-027 Reset mid-op: start, then assert rst_n=0 before the next edge -> valid=0 and y=0 immediately, with no valid after release.
